// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard scheduler: scan-code constants,
// scheduler state encoding and the key event record.
package ps2_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;

    localparam int EVT_W = 10;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b000_0001,
        ST_ARM     = 7'b000_0010,
        ST_WAIT    = 7'b000_0100,
        ST_EVAL    = 7'b000_1000,
        ST_DECODE  = 7'b001_0000,
        ST_GAP     = 7'b010_0000,
        ST_BACKOFF = 7'b100_0000
    } sched_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    // Keyboard overrun markers count as errors rather than keys.
    function automatic logic is_overrun(input logic [7:0] b);
        return (b == SC_00) || (b == SC_FF);
    endfunction

    // BAT pass, ACK and resend carry no key information.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == SC_AA) || (b == SC_FA) || (b == SC_FE);
    endfunction

    function automatic logic is_key_byte(input logic [7:0] b);
        return !((b == SC_E0) || (b == SC_E1) || (b == SC_F0) ||
                 is_overrun(b) || is_ignored(b));
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded key events.
// DEPTH must be a power of two so the pointers wrap naturally.
module key_evt_fifo
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
)
(
    input  logic             clock_quarter,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock_quarter) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_sched.sv
// Arms ps2_rx frame by frame, retries after idle polls or errors, and folds
// scan-code prefixes into key events buffered for the report builder.
//
//  state   | meaning
//  IDLE    | wait for enable, receiver idle and a free FIFO slot
//  ARM     | pulse rx_start, clear frame cycle counter
//  WAIT    | count cycles until rx_finish, latch byte and error flag
//  EVAL    | classify frame: timeout, failed frame or good byte
//  DECODE  | apply prefix/skip rules, push a key event if complete
//  GAP     | short pause after an idle-poll timeout
//  BACKOFF | long pause after a failed frame
module ps2_kbd_sched
    import ps2_pkg::*;
#(
    parameter int FRAME_MIN_CYC = 40,
    parameter int POLL_GAP_CYC  = 8,
    parameter int BACKOFF_CYC   = 64,
    parameter int FIFO_DEPTH    = 4
)
(
    input  logic       clock_quarter,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx_ready,
    input  logic       rx_finish,
    input  logic       rx_faild,
    input  logic [7:0] rx_buffer,
    output logic       rx_start,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] FRAME_MIN  = 8'(FRAME_MIN_CYC);
    localparam logic [7:0] GAP_LD     = 8'(POLL_GAP_CYC);
    localparam logic [7:0] BACKOFF_LD = 8'(BACKOFF_CYC);

    sched_state_t state;
    sched_state_t state_nxt;

    logic [7:0] cyc_cnt;
    logic [7:0] tmr;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       ext_flag;
    logic       brk_flag;
    logic [2:0] skip_cnt;

    logic       evt_push;
    key_evt_t   evt_push_data;
    key_evt_t   evt_head;
    logic       fifo_full;
    logic       fifo_empty;

    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rx_start      = 1'b0;
        evt_push      = 1'b0;
        evt_push_data = '{ext: ext_flag, brk: brk_flag, code: rx_byte};
        case (state)
            ST_IDLE: begin
                if (enable && rx_ready && !fifo_full) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                rx_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rx_finish) begin
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (cyc_cnt < FRAME_MIN) begin
                    state_nxt = ST_GAP;
                end else if (rx_err) begin
                    state_nxt = ST_BACKOFF;
                end else begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = ST_IDLE;
                if (skip_cnt != 3'd0) begin
                    // Last byte of the Pause sequence emits a single E1 event.
                    if (skip_cnt == 3'd1) begin
                        evt_push      = 1'b1;
                        evt_push_data = '{ext: 1'b0, brk: 1'b0, code: SC_E1};
                    end
                end else if (is_key_byte(rx_byte)) begin
                    evt_push = 1'b1;
                end
            end
            ST_GAP, ST_BACKOFF: begin
                if (tmr <= 8'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            cyc_cnt  <= '0;
            tmr      <= '0;
            rx_byte  <= '0;
            rx_err   <= 1'b0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            skip_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                ST_ARM: begin
                    cyc_cnt <= '0;
                end
                ST_WAIT: begin
                    if (cyc_cnt != 8'hFF) begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                    if (rx_finish) begin
                        rx_byte <= rx_buffer;
                        rx_err  <= rx_faild;
                    end
                end
                ST_EVAL: begin
                    if (cyc_cnt < FRAME_MIN) begin
                        tmr <= GAP_LD;
                    end else if (rx_err) begin
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                        skip_cnt <= '0;
                        tmr      <= BACKOFF_LD;
                    end
                end
                ST_DECODE: begin
                    if (skip_cnt != 3'd0) begin
                        skip_cnt <= skip_cnt - 3'd1;
                    end else if (rx_byte == SC_E1) begin
                        skip_cnt <= 3'd7;
                    end else if (rx_byte == SC_E0) begin
                        ext_flag <= 1'b1;
                    end else if (rx_byte == SC_F0) begin
                        brk_flag <= 1'b1;
                    end else if (is_overrun(rx_byte)) begin
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end else if (!is_ignored(rx_byte)) begin
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end
                end
                ST_GAP, ST_BACKOFF: begin
                    if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    key_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_quarter (clock_quarter),
        .reset         (reset),
        .push          (evt_push),
        .push_data     (evt_push_data),
        .pop           (evt_ready),
        .pop_data      (evt_head),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = evt_head.code;
    assign evt_ext   = evt_head.ext;
    assign evt_break = evt_head.brk;

endmodule
